// File: rtl/lcd_ctrl_param_pkg.sv
// Shared definitions for the parametrised LCD image controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lcd_ctrl_pkg;

   localparam logic [3:0] CMD_WRITE  = 4'h0;
   localparam logic [3:0] CMD_UP     = 4'h1;
   localparam logic [3:0] CMD_DOWN   = 4'h2;
   localparam logic [3:0] CMD_LEFT   = 4'h3;
   localparam logic [3:0] CMD_RIGHT  = 4'h4;
   localparam logic [3:0] CMD_MAX    = 4'h5;
   localparam logic [3:0] CMD_MIN    = 4'h6;
   localparam logic [3:0] CMD_AVG    = 4'h7;
   localparam logic [3:0] CMD_CCW    = 4'h8;
   localparam logic [3:0] CMD_CW     = 4'h9;
   localparam logic [3:0] CMD_MIRX   = 4'hA;
   localparam logic [3:0] CMD_MIRY   = 4'hB;
   localparam logic [3:0] CMD_INV    = 4'hC;
   localparam logic [3:0] CMD_RELOAD = 4'hD;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_IDLE,
      ST_EXEC,
      ST_WRITE,
      ST_DONE
   } state_t;

   // Linear buffer index of pixel (c,r) in an image w pixels wide.
   function automatic int unsigned pix_idx(input int unsigned c,
                                           input int unsigned r,
                                           input int unsigned w);
      return r * w + c;
   endfunction

endpackage

// File: rtl/lcd_ctrl_param_blk_op.sv
// 2x2 block operator: max/min/average, rotations, mirrors, invert.
// Latency: purely combinational.
// Backpressure: none; unknown commands pass the block through unchanged.
module lcd_blk_op
   import lcd_ctrl_pkg::*;
#(
   parameter int DW = 8
)(
   input  logic [3:0]    cmd,
   input  logic [DW-1:0] tl,
   input  logic [DW-1:0] tr,
   input  logic [DW-1:0] bl,
   input  logic [DW-1:0] br,
   output logic [DW-1:0] tl_n,
   output logic [DW-1:0] tr_n,
   output logic [DW-1:0] bl_n,
   output logic [DW-1:0] br_n
);

   logic [DW-1:0] mx_top, mx_bot, mx;
   logic [DW-1:0] mn_top, mn_bot, mn;
   logic [DW+1:0] sum;
   logic [DW-1:0] avg;

   // Reductions over the four pixels; the sum carries two guard bits so it never overflows.
   always_comb begin
      mx_top = (tl > tr) ? tl : tr;
      mx_bot = (bl > br) ? bl : br;
      mx     = (mx_top > mx_bot) ? mx_top : mx_bot;
      mn_top = (tl < tr) ? tl : tr;
      mn_bot = (bl < br) ? bl : br;
      mn     = (mn_top < mn_bot) ? mn_top : mn_bot;
      sum    = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
      avg    = sum[DW+1:2];
   end

   // Per-command remap of the block.
   always_comb begin
      tl_n = tl;
      tr_n = tr;
      bl_n = bl;
      br_n = br;
      case (cmd)
         CMD_MAX: begin tl_n = mx;  tr_n = mx;  bl_n = mx;  br_n = mx;  end
         CMD_MIN: begin tl_n = mn;  tr_n = mn;  bl_n = mn;  br_n = mn;  end
         CMD_AVG: begin tl_n = avg; tr_n = avg; bl_n = avg; br_n = avg; end
         CMD_CCW: begin tl_n = tr;  tr_n = br;  br_n = bl;  bl_n = tl;  end
         CMD_CW:  begin tl_n = bl;  tr_n = tl;  br_n = tr;  bl_n = br;  end
         CMD_MIRX: begin tl_n = bl; tr_n = br;  bl_n = tl;  br_n = tr;  end
         CMD_MIRY: begin tl_n = tr; tr_n = tl;  bl_n = br;  br_n = bl;  end
         CMD_INV: begin tl_n = ~tl; tr_n = ~tr; bl_n = ~bl; br_n = ~br; end
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads IROM into a buffer, edits 2x2 blocks, dumps to IRAM.
// Latency: load N+1 cycles, block command 1 cycle, write N+1 cycles plus a done cycle.
// Backpressure: busy high means cmd_valid is ignored; nothing is queued.
module lcd_ctrl_param
   import lcd_ctrl_pkg::*;
#(
   parameter  int IMG_W = 8,
   parameter  int IMG_H = 8,
   parameter  int DW    = 8,
   localparam int AW    = $clog2(IMG_W * IMG_H)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   output logic          IROM_rd,
   output logic [AW-1:0] IROM_A,
   input  logic [DW-1:0] IROM_Q,
   output logic          IRAM_valid,
   output logic [DW-1:0] IRAM_D,
   output logic [AW-1:0] IRAM_A,
   output logic          busy,
   output logic          done
);

   localparam int N    = IMG_W * IMG_H;
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);
   localparam int CNTW = AW + 1;

   localparam logic [XW-1:0]   X_ONE  = XW'(1);
   localparam logic [YW-1:0]   Y_ONE  = YW'(1);
   localparam logic [XW-1:0]   X_MAX  = XW'(IMG_W - 1);
   localparam logic [YW-1:0]   Y_MAX  = YW'(IMG_H - 1);
   localparam logic [CNTW-1:0] CNT_N  = CNTW'(N);

   state_t          state, state_n;
   logic [CNTW-1:0] cnt;
   logic [3:0]      op;
   logic [XW-1:0]   x, x_m1;
   logic [YW-1:0]   y, y_m1;
   logic [DW-1:0]   mem [N];
   logic [AW-1:0]   a_tl, a_tr, a_bl, a_br;
   logic [DW-1:0]   n_tl, n_tr, n_bl, n_br;
   logic            blk_wr;

   assign x_m1   = x - X_ONE;
   assign y_m1   = y - Y_ONE;
   assign a_tl   = AW'(pix_idx(32'(x_m1), 32'(y_m1), IMG_W));
   assign a_tr   = AW'(pix_idx(32'(x),    32'(y_m1), IMG_W));
   assign a_bl   = AW'(pix_idx(32'(x_m1), 32'(y),    IMG_W));
   assign a_br   = AW'(pix_idx(32'(x),    32'(y),    IMG_W));
   assign blk_wr = (op >= CMD_MAX) && (op <= CMD_INV);

   lcd_blk_op #(.DW(DW)) u_blk_op (
      .cmd  (op),
      .tl   (mem[a_tl]),
      .tr   (mem[a_tr]),
      .bl   (mem[a_bl]),
      .br   (mem[a_br]),
      .tl_n (n_tl),
      .tr_n (n_tr),
      .bl_n (n_bl),
      .br_n (n_br)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_LOAD;
      else       state <= state_n;
   end

   // Next-state decode; a command is taken only while sitting in IDLE.
   always_comb begin
      state_n = state;
      case (state)
         ST_LOAD:  if (cnt == CNT_N) state_n = ST_IDLE;
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd == CMD_WRITE)       state_n = ST_WRITE;
               else if (cmd == CMD_RELOAD) state_n = ST_LOAD;
               else                        state_n = ST_EXEC;
            end
         end
         ST_EXEC:  state_n = ST_IDLE;
         ST_WRITE: if (cnt == CNT_N) state_n = ST_DONE;
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_LOAD;
      endcase
   end

   // Registered interface outputs and the shared load/write beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         op         <= '0;
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         IRAM_valid <= 1'b0;
         IRAM_D     <= '0;
         IRAM_A     <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
      end else begin
         busy       <= (state_n != ST_IDLE);
         done       <= (state_n == ST_DONE);
         IROM_rd    <= 1'b0;
         IRAM_valid <= 1'b0;
         if (state == ST_IDLE && cmd_valid) op <= cmd;
         if (state == ST_LOAD && cnt < CNT_N) begin
            IROM_rd <= 1'b1;
            IROM_A  <= cnt[AW-1:0];
         end
         if (state == ST_WRITE && cnt < CNT_N) begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= cnt[AW-1:0];
            IRAM_D     <= mem[cnt[AW-1:0]];
         end
         // Every load or write phase starts counting from zero on entry.
         if (state != state_n)
            cnt <= '0;
         else if ((state == ST_LOAD || state == ST_WRITE) && cnt < CNT_N)
            cnt <= cnt + CNTW'(1);
      end
   end

   // Operation-block pointer; moves saturate at the image edge. Reload keeps it.
   always_ff @(posedge clk) begin
      if (reset) begin
         x <= XW'(IMG_W / 2);
         y <= YW'(IMG_H / 2);
      end else if (state == ST_EXEC) begin
         case (op)
            CMD_UP:    if (y > Y_ONE) y <= y - Y_ONE;
            CMD_DOWN:  if (y < Y_MAX) y <= y + Y_ONE;
            CMD_LEFT:  if (x > X_ONE) x <= x - X_ONE;
            CMD_RIGHT: if (x < X_MAX) x <= x + X_ONE;
            default: ;
         endcase
      end
   end

   // Image buffer: IROM data lands one cycle after its address; block edits land at the end of EXEC.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (IROM_rd) mem[IROM_A] <= IROM_Q;
         if (state == ST_EXEC && blk_wr) begin
            mem[a_tl] <= n_tl;
            mem[a_tr] <= n_tr;
            mem[a_bl] <= n_bl;
            mem[a_br] <= n_br;
         end
      end
   end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
`timescale 1ns/1ps
module tb_lcd_ctrl_param;
   import lcd_ctrl_pkg::*;

   typedef struct packed {
      logic [9:0] addr;
      logic [9:0] data;
   } beat_t;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Instance A: default 8x8, 8-bit pixels
   logic       a_reset, a_cmd_valid, a_irom_rd, a_iram_valid, a_busy, a_done;
   logic [3:0] a_cmd;
   logic [5:0] a_irom_a, a_iram_a;
   logic [7:0] a_irom_q, a_iram_d;

   // Instance B: 16x4, 10-bit pixels
   logic       b_reset, b_cmd_valid, b_irom_rd, b_iram_valid, b_busy, b_done;
   logic [3:0] b_cmd;
   logic [5:0] b_irom_a, b_iram_a;
   logic [9:0] b_irom_q, b_iram_d;

   lcd_ctrl_param u_a (
      .clk(clk), .reset(a_reset), .cmd(a_cmd), .cmd_valid(a_cmd_valid),
      .IROM_rd(a_irom_rd), .IROM_A(a_irom_a), .IROM_Q(a_irom_q),
      .IRAM_valid(a_iram_valid), .IRAM_D(a_iram_d), .IRAM_A(a_iram_a),
      .busy(a_busy), .done(a_done)
   );

   lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(10)) u_b (
      .clk(clk), .reset(b_reset), .cmd(b_cmd), .cmd_valid(b_cmd_valid),
      .IROM_rd(b_irom_rd), .IROM_A(b_irom_a), .IROM_Q(b_irom_q),
      .IRAM_valid(b_iram_valid), .IRAM_D(b_iram_d), .IRAM_A(b_iram_a),
      .busy(b_busy), .done(b_done)
   );

   logic [7:0] rom_a [64];
   logic [9:0] rom_b [64];
   logic [7:0] img_a [64];
   logic [9:0] img_b [64];
   beat_t      q_a [$];
   beat_t      q_b [$];
   beat_t      ea, eb;

   logic [3:0] op_tbl [9] = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h6, 4'h5, 4'hE};
   // expected TL, TR, BL, BR for a block holding TL=10 TR=20 BL=30 BR=41
   logic [7:0] exp_tbl [9][4] = '{
      '{8'd25,  8'd25,  8'd25,  8'd25},
      '{8'd20,  8'd41,  8'd10,  8'd30},
      '{8'd30,  8'd10,  8'd41,  8'd20},
      '{8'd30,  8'd41,  8'd10,  8'd20},
      '{8'd20,  8'd10,  8'd41,  8'd30},
      '{8'd245, 8'd235, 8'd225, 8'd214},
      '{8'd10,  8'd10,  8'd10,  8'd10},
      '{8'd41,  8'd41,  8'd41,  8'd41},
      '{8'd10,  8'd20,  8'd30,  8'd41}
   };

   // IROM models: sample address on the falling edge
   always @(negedge clk) if (a_irom_rd === 1'b1) a_irom_q <= rom_a[a_irom_a];
   always @(negedge clk) if (b_irom_rd === 1'b1) b_irom_q <= rom_b[b_irom_a];

   // IRAM scoreboards: every write beat must match the next expected entry
   always @(negedge clk) begin
      if (a_iram_valid === 1'b1) begin
         n_tests++;
         if (q_a.size() == 0) begin
            n_fail++;
            $display("FAIL iram_a_beat unexpected addr=%0d data=%0d, required no write", a_iram_a, a_iram_d);
         end else begin
            ea = q_a.pop_front();
            if ({4'b0, a_iram_a} !== ea.addr || {2'b0, a_iram_d} !== ea.data) begin
               n_fail++;
               $display("FAIL iram_a_beat got addr=%0d data=%0d, required addr=%0d data=%0d",
                        a_iram_a, a_iram_d, ea.addr, ea.data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_iram_valid === 1'b1) begin
         n_tests++;
         if (q_b.size() == 0) begin
            n_fail++;
            $display("FAIL iram_b_beat unexpected addr=%0d data=%0d, required no write", b_iram_a, b_iram_d);
         end else begin
            eb = q_b.pop_front();
            if ({4'b0, b_iram_a} !== eb.addr || b_iram_d !== eb.data) begin
               n_fail++;
               $display("FAIL iram_b_beat got addr=%0d data=%0d, required addr=%0d data=%0d",
                        b_iram_a, b_iram_d, eb.addr, eb.data);
            end
         end
      end
   end

   function automatic logic busy_of(input bit sel);
      return sel ? b_busy : a_busy;
   endfunction

   function automatic logic done_of(input bit sel);
      return sel ? b_done : a_done;
   endfunction

   task automatic drive_cmd(input bit sel, input logic [3:0] c, input logic v);
      if (sel) begin b_cmd = c; b_cmd_valid = v; end
      else     begin a_cmd = c; a_cmd_valid = v; end
   endtask

   // Waits for busy low, then presents one command for a single rising edge
   task automatic send_cmd(input bit sel, input logic [3:0] c);
      int t;
      t = 0;
      @(negedge clk);
      while (busy_of(sel) !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
      if (busy_of(sel) !== 1'b0) begin
         n_tests++; n_fail++;
         $display("FAIL send_cmd_%0d busy=%b after %0d cycles, required 0", sel, busy_of(sel), t);
      end
      drive_cmd(sel, c, 1'b1);
      @(posedge clk);
      #1 drive_cmd(sel, 4'h0, 1'b0);
   endtask

   // Applies reset, then counts rising edges after release until busy drops
   task automatic do_reset(input bit sel, output int lat);
      drive_cmd(sel, 4'h0, 1'b0);
      if (sel) b_reset = 1'b1; else a_reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (sel) b_reset = 1'b0; else a_reset = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (busy_of(sel) !== 1'b0 && lat < 500);
      for (int k = 0; k < 64; k++) begin img_a[k] = rom_a[k]; img_b[k] = rom_b[k]; end
   endtask

   task automatic push_image(input bit sel);
      beat_t b;
      for (int k = 0; k < 64; k++) begin
         b.addr = 10'(k);
         if (sel) begin b.data = img_b[k];         q_b.push_back(b); end
         else     begin b.data = {2'b0, img_a[k]}; q_a.push_back(b); end
      end
   endtask

   // After a write has been accepted: counts done pulses until busy falls (plus a short tail)
   task automatic wait_write(input bit sel, output int pulses);
      int t;
      pulses = 0;
      t = 0;
      do begin
         @(negedge clk);
         if (done_of(sel) === 1'b1) pulses++;
         t++;
      end while (busy_of(sel) !== 1'b0 && t < 400);
      repeat (3) begin @(negedge clk); if (done_of(sel) === 1'b1) pulses++; end
   endtask

   task automatic test_reset();
      int lat;
      a_reset = 1'b1;
      drive_cmd(0, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({a_irom_rd, a_iram_valid, a_busy, a_done} !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_ctrl rd/valid/busy/done=%b, required 0010", {a_irom_rd, a_iram_valid, a_busy, a_done});
      end
      n_tests++;
      if ({a_irom_a, a_iram_a, a_iram_d} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_data IROM_A=%0d IRAM_A=%0d IRAM_D=%0d, required all 0", a_irom_a, a_iram_a, a_iram_d);
      end
      @(negedge clk);
      a_reset = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (a_irom_rd !== 1'b1 || a_irom_a !== 6'd0) begin
         n_fail++;
         $display("FAIL load_start IROM_rd=%b IROM_A=%0d, required 1 and 0", a_irom_rd, a_irom_a);
      end
      lat = 1;
      while (a_busy !== 1'b0 && lat < 500) begin @(posedge clk); #1; lat++; end
      n_tests++;
      if (lat != 65) begin
         n_fail++;
         $display("FAIL load_latency busy fell after %0d cycles, required 65", lat);
      end
      for (int k = 0; k < 64; k++) img_a[k] = rom_a[k];
   endtask

   task automatic test_write_plain();
      int pulses;
      push_image(0);
      send_cmd(0, CMD_WRITE);
      wait_write(0, pulses);
      n_tests++;
      if (pulses != 1) begin n_fail++; $display("FAIL plain_done_pulses got %0d, required 1", pulses); end
      n_tests++;
      if (q_a.size() != 0) begin n_fail++; $display("FAIL plain_beats_missing %0d left, required 0", q_a.size()); end
   endtask

   task automatic test_shift_clamp_max();
      int lat, pulses;
      logic [7:0] m;
      do_reset(0, lat);
      n_tests++;
      if (lat != 65) begin n_fail++; $display("FAIL clamp_load_latency got %0d, required 65", lat); end
      repeat (4) send_cmd(0, CMD_LEFT);
      repeat (4) send_cmd(0, CMD_UP);
      send_cmd(0, CMD_MAX);
      m = img_a[0];
      if (img_a[1] > m) m = img_a[1];
      if (img_a[8] > m) m = img_a[8];
      if (img_a[9] > m) m = img_a[9];
      img_a[0] = m; img_a[1] = m; img_a[8] = m; img_a[9] = m;
      push_image(0);
      send_cmd(0, CMD_WRITE);
      wait_write(0, pulses);
      n_tests++;
      if (pulses != 1) begin n_fail++; $display("FAIL clamp_done_pulses got %0d, required 1", pulses); end
      n_tests++;
      if (q_a.size() != 0) begin n_fail++; $display("FAIL clamp_beats_missing %0d left, required 0", q_a.size()); end
   endtask

   task automatic test_block_ops();
      int lat, pulses;
      for (int i = 0; i < 9; i++) begin
         do_reset(0, lat);
         send_cmd(0, op_tbl[i]);
         img_a[27] = exp_tbl[i][0];
         img_a[28] = exp_tbl[i][1];
         img_a[35] = exp_tbl[i][2];
         img_a[36] = exp_tbl[i][3];
         push_image(0);
         send_cmd(0, CMD_WRITE);
         wait_write(0, pulses);
         n_tests++;
         if (pulses != 1 || q_a.size() != 0) begin
            n_fail++;
            $display("FAIL blk_op_%h done_pulses=%0d beats_left=%0d, required 1 and 0", op_tbl[i], pulses, q_a.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, p1, p2, p3;
      do_reset(0, lat);
      push_image(0);
      send_cmd(0, CMD_WRITE);
      wait_write(0, p1);
      send_cmd(0, CMD_UP);
      push_image(0);
      send_cmd(0, CMD_WRITE);
      wait_write(0, p2);
      n_tests++;
      if (p1 != 1 || p2 != 1) begin n_fail++; $display("FAIL b2b_done_pulses got %0d,%0d, required 1,1", p1, p2); end
      n_tests++;
      if (q_a.size() != 0) begin n_fail++; $display("FAIL b2b_beats_missing %0d left, required 0", q_a.size()); end
      // pointer moves to (5,3), IROM changes, reload must keep the pointer
      send_cmd(0, CMD_RIGHT);
      rom_a[20] = 8'd255; rom_a[21] = 8'd255; rom_a[28] = 8'd255; rom_a[29] = 8'd253;
      send_cmd(0, CMD_RELOAD);
      send_cmd(0, CMD_AVG);
      for (int k = 0; k < 64; k++) img_a[k] = rom_a[k];
      img_a[20] = 8'd254; img_a[21] = 8'd254; img_a[28] = 8'd254; img_a[29] = 8'd254;
      push_image(0);
      send_cmd(0, CMD_WRITE);
      wait_write(0, p3);
      n_tests++;
      if (p3 != 1 || q_a.size() != 0) begin
         n_fail++;
         $display("FAIL reload_write done_pulses=%0d beats_left=%0d, required 1 and 0", p3, q_a.size());
      end
   endtask

   task automatic test_reset_mid_write();
      int lat, t, bad;
      bit hit;
      do_reset(0, lat);
      push_image(0);
      send_cmd(0, CMD_WRITE);
      hit = 0; t = 0;
      while (!hit && t < 300) begin
         @(negedge clk); t++;
         if (a_iram_valid === 1'b1 && a_iram_a === 6'd19) hit = 1;
      end
      n_tests++;
      if (!hit) begin n_fail++; $display("FAIL midwr_reach beat 19 not seen in %0d cycles, required seen", t); end
      a_reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({a_iram_valid, a_busy, a_irom_rd} !== 3'b010) begin
         n_fail++;
         $display("FAIL midwr_abort valid/busy/rd=%b, required 010", {a_iram_valid, a_busy, a_irom_rd});
      end
      q_a.delete();
      @(negedge clk);
      a_reset = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (a_irom_rd !== 1'b1 || a_irom_a !== 6'd0) begin
         n_fail++;
         $display("FAIL midwr_reload IROM_rd=%b IROM_A=%0d, required 1 and 0", a_irom_rd, a_irom_a);
      end
      for (int i = 0; i < 10; i++) begin
         drive_cmd(0, (i % 2 == 0) ? CMD_WRITE : CMD_LEFT, 1'b1);
         @(posedge clk); #1;
         drive_cmd(0, 4'h0, 1'b0);
         @(posedge clk); #1;
      end
      t = 0;
      while (a_busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_iram_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL busy_cmd_ignored %0d active cycles after load, required 0", bad); end
   endtask

   task automatic test_param_dims();
      int lat, naddr, bad, pulses;
      b_reset = 1'b1;
      drive_cmd(1, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      b_reset = 1'b0;
      lat = 0; naddr = 0; bad = 0;
      do begin
         @(posedge clk); #1; lat++;
         if (b_irom_rd === 1'b1) begin
            if (b_irom_a !== 6'(naddr)) bad++;
            naddr++;
         end
      end while (b_busy !== 1'b0 && lat < 500);
      n_tests++;
      if (naddr != 64 || bad != 0) begin
         n_fail++;
         $display("FAIL b_load_addrs count=%0d out_of_order=%0d, required 64 and 0", naddr, bad);
      end
      n_tests++;
      if (lat != 65) begin n_fail++; $display("FAIL b_load_latency got %0d, required 65", lat); end
      for (int k = 0; k < 64; k++) img_b[k] = rom_b[k];
      repeat (3) send_cmd(1, CMD_DOWN);
      send_cmd(1, CMD_INV);
      img_b[39] = 10'd1023 - rom_b[39];
      img_b[40] = 10'd1023 - rom_b[40];
      img_b[55] = 10'd1023 - rom_b[55];
      img_b[56] = 10'd1023 - rom_b[56];
      push_image(1);
      send_cmd(1, CMD_WRITE);
      wait_write(1, pulses);
      n_tests++;
      if (pulses != 1 || q_b.size() != 0) begin
         n_fail++;
         $display("FAIL b_invert_write done_pulses=%0d beats_left=%0d, required 1 and 0", pulses, q_b.size());
      end
   endtask

   initial begin
      a_reset = 1'b1; b_reset = 1'b1;
      a_cmd = 4'h0; a_cmd_valid = 1'b0;
      b_cmd = 4'h0; b_cmd_valid = 1'b0;
      for (int k = 0; k < 64; k++) begin
         rom_a[k] = 8'((k * 37 + 11) % 256);
         rom_b[k] = 10'((k * 97 + 5) % 1024);
      end
      rom_a[27] = 8'd10; rom_a[28] = 8'd20; rom_a[35] = 8'd30; rom_a[36] = 8'd41;

      test_reset();
      test_write_plain();
      test_shift_clamp_max();
      test_block_ops();
      test_back_to_back();
      test_reset_mid_write();
      test_param_dims();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
